// File: rtl/cam_capture_writer_pkg.sv
// Shared definitions for the camera capture writer: default geometry, FSM
// encoding and the RGB565 byte-pair to RGB332 packing.
package cam_capture_writer_pkg;

    localparam int DEF_H_PIXELS = 160;
    localparam int DEF_V_LINES  = 120;
    localparam int DEF_ADDR_W   = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // byte0 = {R[4:0],G[5:3]}, byte1 = {G[2:0],B[4:0]} -> {R[4:2],G[5:3],B[4:3]}
    function automatic logic [7:0] rgb565_to_332(input logic [7:0] byte0,
                                                 input logic [7:0] byte1);
        return {byte0[7:5], byte0[2:0], byte1[4:3]};
    endfunction

endpackage

// File: rtl/cam_capture_writer_sync_edge.sv
// Two-flop synchroniser for one asynchronous camera signal, with registered
// rise/fall pulses aligned to the delayed level output.
module cam_capture_writer_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
            rise <= sync & ~prev;
            fall <= ~sync & prev;
        end
    end

    // Level is taken from the delayed copy so it lines up with the edge pulses.
    assign level = prev;

endmodule

// File: rtl/cam_capture_writer.sv
// Captures OV7670-style RGB565 byte pairs, packs each pixel to RGB332 and
// writes one byte per pixel into the frame buffer.
module cam_capture_writer
    import cam_capture_writer_pkg::*;
#(
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int V_LINES  = DEF_V_LINES,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_Reset,
    input  logic              i_Cam_Pclk,
    input  logic              i_Cam_Href,
    input  logic              i_Cam_Vsync,
    input  logic [7:0]        i_Cam_Data,
    input  logic              i_Capture_Enable,
    output logic [ADDR_W-1:0] o_Write_Adress,
    output logic [7:0]        o_Data,
    output logic              o_Enable_Write,
    output logic              o_Frame_Done,
    output logic              o_Busy,
    output logic              o_Overflow,
    output logic [1:0]        o_State
);

    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);
    localparam logic [ADDR_W-1:0] V_LIM  = ADDR_W'(V_LINES);

    logic pclk_s, pclk_rise, pclk_fall;
    logic href_s, href_rise, href_fall;
    logic vsync_s, vsync_rise, vsync_fall;
    logic unused_edges;

    cam_capture_writer_sync_edge u_pclk (
        .clk(i_clk), .rst(i_Reset), .async_in(i_Cam_Pclk),
        .level(pclk_s), .rise(pclk_rise), .fall(pclk_fall)
    );
    cam_capture_writer_sync_edge u_href (
        .clk(i_clk), .rst(i_Reset), .async_in(i_Cam_Href),
        .level(href_s), .rise(href_rise), .fall(href_fall)
    );
    cam_capture_writer_sync_edge u_vsync (
        .clk(i_clk), .rst(i_Reset), .async_in(i_Cam_Vsync),
        .level(vsync_s), .rise(vsync_rise), .fall(vsync_fall)
    );

    assign unused_edges = ^{pclk_s, pclk_fall, href_rise};

    logic [7:0] data_meta;
    logic [7:0] data_s;

    always_ff @(posedge i_clk or posedge i_Reset) begin
        if (i_Reset) begin
            data_meta <= 8'd0;
            data_s    <= 8'd0;
        end else begin
            data_meta <= i_Cam_Data;
            data_s    <= data_meta;
        end
    end

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] line;
    logic              phase;
    logic              line_has_byte;
    logic [7:0]        byte0;
    logic              wr_pend;
    logic [7:0]        pend_data;
    logic [ADDR_W-1:0] pend_addr;

    always_ff @(posedge i_clk or posedge i_Reset) begin
        if (i_Reset) begin
            state          <= ST_IDLE;
            addr           <= '0;
            line_base      <= '0;
            col            <= '0;
            line           <= '0;
            phase          <= 1'b0;
            line_has_byte  <= 1'b0;
            byte0          <= 8'd0;
            wr_pend        <= 1'b0;
            pend_data      <= 8'd0;
            pend_addr      <= '0;
            o_Write_Adress <= '0;
            o_Data         <= 8'd0;
            o_Enable_Write <= 1'b0;
            o_Frame_Done   <= 1'b0;
            o_Busy         <= 1'b0;
            o_Overflow     <= 1'b0;
        end else begin
            wr_pend        <= 1'b0;
            o_Enable_Write <= wr_pend;
            o_Frame_Done   <= 1'b0;
            // Output bus only moves with a strobe so the RAM sees stable values.
            if (wr_pend) begin
                o_Data         <= pend_data;
                o_Write_Adress <= pend_addr;
            end
            case (state)
                ST_IDLE: begin
                    if (i_Capture_Enable && vsync_s) begin
                        state  <= ST_ARMED;
                        o_Busy <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (vsync_fall) begin
                        state         <= ST_CAPTURE;
                        addr          <= '0;
                        line_base     <= '0;
                        col           <= '0;
                        line          <= '0;
                        phase         <= 1'b0;
                        line_has_byte <= 1'b0;
                        o_Overflow    <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (vsync_rise) begin
                        state        <= ST_DONE;
                        o_Frame_Done <= 1'b1;
                        o_Busy       <= 1'b0;
                    end else if (href_fall) begin
                        phase <= 1'b0;
                        col   <= '0;
                        // Short lines still leave the next line at its row base.
                        if (line_has_byte) begin
                            line_has_byte <= 1'b0;
                            if (line < V_LIM) begin
                                line      <= line + 1'b1;
                                line_base <= line_base + H_STEP;
                                addr      <= line_base + H_STEP;
                            end
                        end
                    end else if (pclk_rise && href_s) begin
                        line_has_byte <= 1'b1;
                        if (!phase) begin
                            byte0 <= data_s;
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (col < H_STEP && line < V_LIM) begin
                                wr_pend   <= 1'b1;
                                pend_data <= rgb565_to_332(byte0, data_s);
                                pend_addr <= addr;
                                addr      <= addr + 1'b1;
                                col       <= col + 1'b1;
                            end else begin
                                o_Overflow <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_State = state;

endmodule

// File: tb/tb_cam_capture_writer.sv
// Directed camera-frame bench for cam_capture_writer with a scoreboard of
// expected {address, pixel} writes checked by an independent monitor.
module tb_cam_capture_writer;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 6;
    localparam int W  = AW + 8;

    logic          i_clk = 1'b0;
    logic          i_Reset = 1'b1;
    logic          i_Cam_Pclk = 1'b0;
    logic          i_Cam_Href = 1'b0;
    logic          i_Cam_Vsync = 1'b0;
    logic [7:0]    i_Cam_Data = 8'd0;
    logic          i_Capture_Enable = 1'b1;
    logic [AW-1:0] o_Write_Adress;
    logic [7:0]    o_Data;
    logic          o_Enable_Write;
    logic          o_Frame_Done;
    logic          o_Busy;
    logic          o_Overflow;
    logic [1:0]    o_State;

    cam_capture_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .i_clk(i_clk),
        .i_Reset(i_Reset),
        .i_Cam_Pclk(i_Cam_Pclk),
        .i_Cam_Href(i_Cam_Href),
        .i_Cam_Vsync(i_Cam_Vsync),
        .i_Cam_Data(i_Cam_Data),
        .i_Capture_Enable(i_Capture_Enable),
        .o_Write_Adress(o_Write_Adress),
        .o_Data(o_Data),
        .o_Enable_Write(o_Enable_Write),
        .o_Frame_Done(o_Frame_Done),
        .o_Busy(o_Busy),
        .o_Overflow(o_Overflow),
        .o_State(o_State)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    int wr_cnt = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [AW-1:0] last_addr = '0;

    // frame model
    bit m_expect = 1'b0;
    int m_line = 0;
    bit m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // monitor
    always @(negedge i_clk) begin
        if (!i_Reset) begin
            if (o_Enable_Write) begin
                wr_cnt++;
                last_addr = o_Write_Adress;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL write_unexpected actual=%0h/%0h required=none t=%0t",
                             o_Write_Adress, o_Data, $time);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("write", 32'({o_Write_Adress, o_Data}), 32'(e));
                end
            end
            if (o_Frame_Done) done_cnt++;
        end
    end

    // drivers
    task automatic send_byte(input logic [7:0] b);
        i_Cam_Data = b;
        repeat (4) @(negedge i_clk);
        i_Cam_Pclk = 1'b1;
        repeat (4) @(negedge i_clk);
        i_Cam_Pclk = 1'b0;
    endtask

    task automatic send_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] exp_d);
        int npix;
        npix = nbytes / 2;
        if (m_expect) begin
            for (int i = 0; i < npix; i++) begin
                if (m_line < V && i < H) exp_q.push_back({AW'(m_line * H + i), exp_d});
                else m_ovf = 1'b1;
            end
            if (nbytes > 0) m_line++;
        end
        i_Cam_Href = 1'b1;
        repeat (2) @(negedge i_clk);
        for (int j = 0; j < nbytes; j++) send_byte((j % 2 == 0) ? b0 : b1);
        repeat (2) @(negedge i_clk);
        i_Cam_Href = 1'b0;
        repeat (6) @(negedge i_clk);
    endtask

    task automatic frame_begin(input bit expect_cap);
        i_Cam_Vsync = 1'b1;
        repeat (12) @(negedge i_clk);
        m_expect = expect_cap;
        m_line = 0;
        m_ovf = 1'b0;
        i_Cam_Vsync = 1'b0;
        repeat (12) @(negedge i_clk);
    endtask

    task automatic frame_end();
        i_Cam_Vsync = 1'b1;
        repeat (12) @(negedge i_clk);
        if (m_expect) exp_done++;
        m_expect = 1'b0;
    endtask

    initial begin
        int wr0;
        repeat (3) @(negedge i_clk);
        chk("reset_we", 32'(o_Enable_Write), 32'd0);
        chk("reset_addr", 32'(o_Write_Adress), 32'd0);
        chk("reset_data", 32'(o_Data), 32'd0);
        chk("reset_busy", 32'(o_Busy), 32'd0);
        chk("reset_ovf", 32'(o_Overflow), 32'd0);
        chk("reset_state", 32'(o_State), 32'd0);
        i_Reset = 1'b0;
        repeat (3) @(negedge i_clk);

        // write latency: strobe 4 clocks after second-byte PCLK is first sampled
        frame_begin(1'b1);
        i_Cam_Href = 1'b1;
        repeat (2) @(negedge i_clk);
        send_byte(8'h47);
        i_Cam_Data = 8'hB5;
        repeat (4) @(negedge i_clk);
        exp_q.push_back({AW'(0), 8'h5E});
        i_Cam_Pclk = 1'b1;
        repeat (4) @(negedge i_clk);
        chk("latency_early", 32'(o_Enable_Write), 32'd0);
        i_Cam_Pclk = 1'b0;
        @(negedge i_clk);
        chk("latency_at4", 32'(o_Enable_Write), 32'd1);
        chk("busy_capture", 32'(o_Busy), 32'd1);
        repeat (4) @(negedge i_clk);
        i_Cam_Href = 1'b0;
        repeat (6) @(negedge i_clk);
        frame_end();
        chk("done_latency", 32'(done_cnt), 32'(exp_done));

        // full frame of 0xE0,0x1F -> 0xE3
        wr0 = wr_cnt;
        frame_begin(1'b1);
        for (int l = 0; l < V; l++) send_line(2 * H, 8'hE0, 8'h1F, 8'hE3);
        frame_end();
        chk("full_count", 32'(wr_cnt - wr0), 32'(H * V));
        chk("full_last_addr", 32'(last_addr), 32'(H * V - 1));
        chk("full_done", 32'(done_cnt), 32'(exp_done));
        chk("full_ovf", 32'(o_Overflow), 32'(m_ovf));

        // long line then short line
        frame_begin(1'b1);
        send_line(2 * (H + 2), 8'h12, 8'h34, 8'h0A);
        send_line(2 * H, 8'hE0, 8'h1F, 8'hE3);
        send_line(8, 8'h47, 8'hB5, 8'h5E);
        send_line(2 * H, 8'hFF, 8'hFF, 8'hFF);
        frame_end();
        chk("long_ovf", 32'(o_Overflow), 32'd1);
        chk("long_done", 32'(done_cnt), 32'(exp_done));

        // extra lines beyond V
        wr0 = wr_cnt;
        frame_begin(1'b1);
        for (int l = 0; l < V + 2; l++) send_line(2 * H, 8'h47, 8'hB5, 8'h5E);
        frame_end();
        chk("lines_count", 32'(wr_cnt - wr0), 32'(H * V));
        chk("lines_last_addr", 32'(last_addr), 32'(H * V - 1));
        chk("lines_ovf", 32'(o_Overflow), 32'd1);

        // odd byte count: stray byte dropped, next line restarts at phase 0
        frame_begin(1'b1);
        send_line(2 * H + 1, 8'h12, 8'h34, 8'h0A);
        send_line(2 * H, 8'hE0, 8'h1F, 8'hE3);
        send_line(7, 8'hFF, 8'hFF, 8'hFF);
        send_line(2 * H, 8'h47, 8'hB5, 8'h5E);
        frame_end();
        chk("odd_ovf", 32'(o_Overflow), 32'd0);
        chk("odd_done", 32'(done_cnt), 32'(exp_done));

        // reset mid-frame, then a clean frame from address 0
        frame_begin(1'b1);
        send_line(2 * H, 8'hE0, 8'h1F, 8'hE3);
        send_line(2 * H, 8'hE0, 8'h1F, 8'hE3);
        @(negedge i_clk);
        i_Reset = 1'b1;
        #1;
        chk("midrst_we", 32'(o_Enable_Write), 32'd0);
        chk("midrst_addr", 32'(o_Write_Adress), 32'd0);
        chk("midrst_data", 32'(o_Data), 32'd0);
        chk("midrst_busy", 32'(o_Busy), 32'd0);
        @(negedge i_clk);
        i_Reset = 1'b0;
        m_expect = 1'b0;
        send_line(2 * H, 8'hE0, 8'h1F, 8'hE3);
        send_line(2 * H, 8'hE0, 8'h1F, 8'hE3);
        frame_end();
        chk("midrst_no_done", 32'(done_cnt), 32'(exp_done));
        frame_begin(1'b1);
        for (int l = 0; l < V; l++) send_line(2 * H, 8'hFF, 8'hFF, 8'hFF);
        frame_end();
        chk("after_rst_done", 32'(done_cnt), 32'(exp_done));

        // enable dropped mid-frame: frame completes, no further frame
        frame_begin(1'b1);
        send_line(2 * H, 8'h12, 8'h34, 8'h0A);
        i_Capture_Enable = 1'b0;
        for (int l = 1; l < V; l++) send_line(2 * H, 8'h12, 8'h34, 8'h0A);
        frame_end();
        chk("drop_en_done", 32'(done_cnt), 32'(exp_done));

        // enable low before vsync: nothing captured
        wr0 = wr_cnt;
        frame_begin(1'b0);
        send_line(2 * H, 8'hE0, 8'h1F, 8'hE3);
        chk("disabled_busy", 32'(o_Busy), 32'd0);
        send_line(2 * H, 8'hE0, 8'h1F, 8'hE3);
        frame_end();
        chk("disabled_count", 32'(wr_cnt - wr0), 32'd0);
        chk("disabled_done", 32'(done_cnt), 32'(exp_done));
        chk("disabled_state", 32'(o_State), 32'd0);

        repeat (5) @(negedge i_clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
